// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: latches the decode control word and the operand,
// immediate and PC+4 data paths for the EXE stage, produces the ebubble/ewreg/
// em2reg/ern feedback used by the control unit, and keeps saturating stall,
// bubble and issue performance counters.
module id_exe_reg #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             dwreg,
  input  logic             dm2reg,
  input  logic             dwmem,
  input  logic [3:0]       daluc,
  input  logic             daluimm,
  input  logic             dshift,
  input  logic             djal,
  input  logic [1:0]       dpcsource,
  input  logic             wpcir,
  input  logic [31:0]      da,
  input  logic [31:0]      db,
  input  logic [31:0]      dimm,
  input  logic [4:0]       drn,
  input  logic [31:0]      dpc4,
  input  logic             cnt_clr,
  output logic             ewreg,
  output logic             em2reg,
  output logic             ewmem,
  output logic             ejal,
  output logic             ealuimm,
  output logic             eshift,
  output logic [3:0]       ealuc,
  output logic [31:0]      ea,
  output logic [31:0]      eb,
  output logic [31:0]      eimm,
  output logic [31:0]      epc4,
  output logic [4:0]       ern,
  output logic             ebubble,
  output logic             evalid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] issue_cnt
);

  logic             wreg_q, m2reg_q, wmem_q, jal_q, aluimm_q, shift_q;
  logic             wreg_d, m2reg_d, wmem_d, jal_d, aluimm_d, shift_d;
  logic [3:0]       aluc_q, aluc_d;
  logic [31:0]      a_q, b_q, imm_q, pc4_q;
  logic [4:0]       rn_q;
  logic             bubble_q, bubble_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;
  logic [CNT_W-1:0] issue_q, issue_d;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Next-state for the control word, bubble/valid flags and counters.
  always_comb begin
    wreg_d   = dwreg   & wpcir;
    m2reg_d  = dm2reg  & wpcir;
    wmem_d   = dwmem   & wpcir;
    jal_d    = djal    & wpcir;
    aluimm_d = daluimm & wpcir;
    shift_d  = dshift  & wpcir;
    aluc_d   = wpcir ? daluc : '0;
    bubble_d = (dpcsource != 2'b00) & wpcir;
    valid_d  = wpcir & ~bubble_q;
    stall_d   = stall_q;
    bub_cnt_d = bub_cnt_q;
    issue_d   = issue_q;
    if (cnt_clr) begin
      stall_d   = '0;
      bub_cnt_d = '0;
      issue_d   = '0;
    end else begin
      if (!wpcir)             stall_d   = sat_inc(stall_q);
      if (bubble_q)           bub_cnt_d = sat_inc(bub_cnt_q);
      if (wpcir && !bubble_q) issue_d   = sat_inc(issue_q);
    end
  end

  // Pipeline register state; loads every edge, cleared asynchronously.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wreg_q    <= 1'b0;
      m2reg_q   <= 1'b0;
      wmem_q    <= 1'b0;
      jal_q     <= 1'b0;
      aluimm_q  <= 1'b0;
      shift_q   <= 1'b0;
      aluc_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      pc4_q     <= '0;
      rn_q      <= '0;
      bubble_q  <= 1'b0;
      valid_q   <= 1'b0;
      stall_q   <= '0;
      bub_cnt_q <= '0;
      issue_q   <= '0;
    end else begin
      wreg_q    <= wreg_d;
      m2reg_q   <= m2reg_d;
      wmem_q    <= wmem_d;
      jal_q     <= jal_d;
      aluimm_q  <= aluimm_d;
      shift_q   <= shift_d;
      aluc_q    <= aluc_d;
      a_q       <= da;
      b_q       <= db;
      imm_q     <= dimm;
      pc4_q     <= dpc4;
      rn_q      <= drn;
      bubble_q  <= bubble_d;
      valid_q   <= valid_d;
      stall_q   <= stall_d;
      bub_cnt_q <= bub_cnt_d;
      issue_q   <= issue_d;
    end
  end

  assign ewreg      = wreg_q;
  assign em2reg     = m2reg_q;
  assign ewmem      = wmem_q;
  assign ejal       = jal_q;
  assign ealuimm    = aluimm_q;
  assign eshift     = shift_q;
  assign ealuc      = aluc_q;
  assign ea         = a_q;
  assign eb         = b_q;
  assign eimm       = imm_q;
  assign epc4       = pc4_q;
  // jal links into r31 regardless of the decoded destination.
  assign ern        = jal_q ? 5'd31 : rn_q;
  assign ebubble    = bubble_q;
  assign evalid     = valid_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bub_cnt_q;
  assign issue_cnt  = issue_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard bench for id_exe_reg: the driver pushes the expected EXE view for
// each applied vector, a monitor pops and compares one cycle later.
module tb_id_exe_reg;

  localparam int unsigned CW = 4;

  logic          clock = 1'b0;
  logic          resetn;
  logic          dwreg, dm2reg, dwmem, daluimm, dshift, djal, wpcir, cnt_clr;
  logic [3:0]    daluc;
  logic [1:0]    dpcsource;
  logic [31:0]   da, db, dimm, dpc4;
  logic [4:0]    drn;
  logic          ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ebubble, evalid;
  logic [3:0]    ealuc;
  logic [31:0]   ea, eb, eimm, epc4;
  logic [4:0]    ern;
  logic [CW-1:0] stall_cnt, bubble_cnt, issue_cnt;

  id_exe_reg #(.CNT_W(CW)) dut (
    .clock(clock), .resetn(resetn), .dwreg(dwreg), .dm2reg(dm2reg),
    .dwmem(dwmem), .daluc(daluc), .daluimm(daluimm), .dshift(dshift),
    .djal(djal), .dpcsource(dpcsource), .wpcir(wpcir), .da(da), .db(db),
    .dimm(dimm), .drn(drn), .dpc4(dpc4), .cnt_clr(cnt_clr),
    .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ejal(ejal),
    .ealuimm(ealuimm), .eshift(eshift), .ealuc(ealuc), .ea(ea), .eb(eb),
    .eimm(eimm), .epc4(epc4), .ern(ern), .ebubble(ebubble), .evalid(evalid),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .issue_cnt(issue_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wreg, m2reg, wmem, jal, aluimm, shift, bub, valid;
    logic [3:0]  aluc;
    logic [31:0] a, b, imm, pc4;
    logic [4:0]  rn;
    logic [CW-1:0] sc, bc, ic;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state tracked by the bench.
  logic          m_bub;
  logic [CW-1:0] m_sc, m_bc, m_ic;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  task automatic model_reset();
    m_bub = 1'b0; m_sc = '0; m_bc = '0; m_ic = '0;
  endtask

  // Apply the current inputs (called at a negedge), push the expectation,
  // then advance to the next negedge.
  task automatic step();
    exp_t e;
    e.wreg   = dwreg   & wpcir;
    e.m2reg  = dm2reg  & wpcir;
    e.wmem   = dwmem   & wpcir;
    e.jal    = djal    & wpcir;
    e.aluimm = daluimm & wpcir;
    e.shift  = dshift  & wpcir;
    e.aluc   = wpcir ? daluc : 4'd0;
    e.a = da; e.b = db; e.imm = dimm; e.pc4 = dpc4;
    e.rn     = e.jal ? 5'd31 : drn;
    e.valid  = wpcir & ~m_bub;
    if (cnt_clr) begin
      m_sc = '0; m_bc = '0; m_ic = '0;
    end else begin
      if (!wpcir) m_sc = inc(m_sc);
      if (m_bub) m_bc = inc(m_bc);
      if (wpcir && !m_bub) m_ic = inc(m_ic);
    end
    m_bub = (dpcsource != 2'b00) & wpcir;
    e.bub = m_bub;
    e.sc = m_sc; e.bc = m_bc; e.ic = m_ic;
    q.push_back(e);
    @(negedge clock);
  endtask

  task automatic set_ctl(input logic wr, input logic m2, input logic wm,
                         input logic [3:0] alu, input logic ai, input logic sh,
                         input logic jl, input logic [1:0] pcs, input logic wp,
                         input logic clr);
    dwreg = wr; dm2reg = m2; dwmem = wm; daluc = alu; daluimm = ai;
    dshift = sh; djal = jl; dpcsource = pcs; wpcir = wp; cnt_clr = clr;
  endtask

  task automatic set_data(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [4:0] rn,
                          input logic [31:0] pc4);
    da = a; db = b; dimm = imm; drn = rn; dpc4 = pc4;
  endtask

  // Monitor: one expectation per loaded edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("ewreg", {31'd0, ewreg}, {31'd0, e.wreg});
        chk("em2reg", {31'd0, em2reg}, {31'd0, e.m2reg});
        chk("ewmem", {31'd0, ewmem}, {31'd0, e.wmem});
        chk("ejal", {31'd0, ejal}, {31'd0, e.jal});
        chk("ealuimm", {31'd0, ealuimm}, {31'd0, e.aluimm});
        chk("eshift", {31'd0, eshift}, {31'd0, e.shift});
        chk("ealuc", {28'd0, ealuc}, {28'd0, e.aluc});
        chk("ea", ea, e.a);
        chk("eb", eb, e.b);
        chk("eimm", eimm, e.imm);
        chk("epc4", epc4, e.pc4);
        chk("ern", {27'd0, ern}, {27'd0, e.rn});
        chk("ebubble", {31'd0, ebubble}, {31'd0, e.bub});
        chk("evalid", {31'd0, evalid}, {31'd0, e.valid});
        chk("stall_cnt", {28'd0, stall_cnt}, {28'd0, e.sc});
        chk("bubble_cnt", {28'd0, bubble_cnt}, {28'd0, e.bc});
        chk("issue_cnt", {28'd0, issue_cnt}, {28'd0, e.ic});
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {26'd0, ewreg, em2reg, ewmem, ejal, ealuimm, eshift}, 32'd0);
    chk({tag, "_ealuc"}, {28'd0, ealuc}, 32'd0);
    chk({tag, "_ea"}, ea, 32'd0);
    chk({tag, "_eb_eimm_epc4"}, eb | eimm | epc4, 32'd0);
    chk({tag, "_ern"}, {27'd0, ern}, 32'd0);
    chk({tag, "_flags"}, {30'd0, ebubble, evalid}, 32'd0);
    chk({tag, "_cnts"}, {20'd0, stall_cnt, bubble_cnt, issue_cnt}, 32'd0);
  endtask

  initial begin
    model_reset();
    resetn = 1'b0;
    set_ctl(1, 1, 1, 4'hA, 1, 1, 1, 2'b10, 1, 0);
    set_data(32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0042, 5'd7, 32'h0000_0104);
    repeat (2) @(negedge clock);
    chk_all_zero("rst_hold");

    // First edge after release loads normally.
    resetn = 1'b1;
    set_ctl(1, 0, 0, 4'b0100, 0, 0, 0, 2'b00, 1, 0);
    set_data(32'h1234, 32'h5678, 32'h9, 5'd3, 32'h8);
    step();
    chk("post_rst_ealuc", {28'd0, ealuc}, 32'h4);
    chk("post_rst_ea", ea, 32'h1234);
    chk("post_rst_ewreg", {31'd0, ewreg}, 32'd1);

    // Asynchronous reset in the middle of a cycle.
    set_ctl(1, 1, 1, 4'h7, 1, 1, 0, 2'b00, 1, 0);
    set_data(32'h1111, 32'h2222, 32'h3333, 5'd9, 32'h4444);
    step();
    #2 resetn = 1'b0;
    #1 chk_all_zero("async_rst");
    @(negedge clock);
    resetn = 1'b1;
    model_reset();

    // jal followed by its cancelled delay-slot instruction.
    set_ctl(0, 0, 0, 4'h0, 0, 0, 0, 2'b00, 1, 1);
    set_data(32'h0, 32'h0, 32'h0, 5'd0, 32'h0);
    step();
    set_ctl(1, 0, 0, 4'h0, 0, 0, 1, 2'b11, 1, 0);
    set_data(32'hA, 32'hB, 32'hC, 5'd0, 32'h0040_0010);
    step();
    chk("jal_ern", {27'd0, ern}, 32'd31);
    chk("jal_ejal", {31'd0, ejal}, 32'd1);
    chk("jal_ebubble", {31'd0, ebubble}, 32'd1);
    set_ctl(0, 0, 0, 4'h0, 0, 0, 0, 2'b00, 1, 0);
    set_data(32'h1, 32'h2, 32'h3, 5'd4, 32'h0040_0014);
    step();
    chk("slot_ebubble", {31'd0, ebubble}, 32'd0);
    chk("slot_evalid", {31'd0, evalid}, 32'd0);
    chk("slot_bubble_cnt", {28'd0, bubble_cnt}, 32'd1);

    // Load-use stall: controls squashed, data still flows.
    set_ctl(1, 1, 1, 4'hF, 1, 1, 1, 2'b00, 0, 0);
    set_data(32'h55AA, 32'hBEEF_0001, 32'h77, 5'd12, 32'h18);
    step();
    chk("stall_ctl", {24'd0, ewreg, ewmem, em2reg, ejal, ealuc}, 32'd0);
    chk("stall_evalid", {31'd0, evalid}, 32'd0);
    chk("stall_eb", eb, 32'hBEEF_0001);
    chk("stall_cnt1", {28'd0, stall_cnt}, 32'd1);

    // Bubble and stall together.
    set_ctl(0, 0, 0, 4'h0, 0, 0, 0, 2'b00, 1, 1);
    step();
    set_ctl(1, 0, 0, 4'h2, 0, 0, 0, 2'b01, 1, 0);
    set_data(32'h10, 32'h20, 32'h30, 5'd5, 32'h40);
    step();
    set_ctl(1, 0, 0, 4'h2, 0, 0, 0, 2'b01, 0, 0);
    step();
    chk("sim_ebubble", {31'd0, ebubble}, 32'd0);
    chk("sim_evalid", {31'd0, evalid}, 32'd0);
    chk("sim_cnts", {20'd0, stall_cnt, bubble_cnt, issue_cnt}, 32'h111);

    // Saturation of issue_cnt, then clear with a pending increment.
    set_ctl(0, 0, 0, 4'h0, 0, 0, 0, 2'b00, 1, 1);
    step();
    set_ctl(1, 0, 0, 4'h3, 1, 0, 0, 2'b00, 1, 0);
    for (int i = 0; i < 20; i++) begin
      set_data(32'(i), 32'(i * 3), 32'(i + 100), 5'(i), 32'(4 * i));
      step();
    end
    chk("sat_issue", {28'd0, issue_cnt}, 32'hF);
    cnt_clr = 1'b1;
    step();
    chk("clr_issue", {28'd0, issue_cnt}, 32'd0);
    cnt_clr = 1'b0;
    step();
    chk("after_clr_issue", {28'd0, issue_cnt}, 32'd1);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clock);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_exe_reg.md
Name: id_exe_reg

Overview:
- ID/EXE pipeline register of the five-stage pipelined CPU.
- Latches the decode-stage control word from the control unit together with the operand and immediate data paths, then presents them to the EXE stage.
- Generates the ebubble, ewreg, em2reg and ern feedback that the control unit uses for its stall, forwarding and branch-cancel logic.
- Holds saturating stall, bubble and issue performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- dwreg  in  1  register write enable from the control unit.
- dm2reg  in  1  load select.
- dwmem  in  1  memory write enable.
- daluc  in  4  ALU op.
- daluimm  in  1  ALU B operand takes the immediate.
- dshift  in  1  ALU A operand takes the shift amount.
- djal  in  1  jal instruction.
- dpcsource  in  2  PC select from the control unit (already qualified).
- wpcir  in  1  0 = load-use stall this cycle.
- da  in  32  forwarded operand A.
- db  in  32  forwarded operand B.
- dimm  in  32  extended immediate.
- drn  in  5  destination register (rt or rd, already selected).
- dpc4  in  32  PC+4 of the decode instruction.
- cnt_clr  in  1  synchronous clear of all counters.
- ewreg, em2reg, ewmem, ejal, ealuimm, eshift  out  1 each  registered controls.
- ealuc  out  4  registered ALU op.
- ea, eb, eimm, epc4  out  32 each  registered data.
- ern  out  5  effective destination: 31 when ejal=1, else the registered drn.
- ebubble  out  1  instruction now in ID is a cancelled delay-slot instruction.
- evalid  out  1  EXE holds a real instruction.
- stall_cnt, bubble_cnt, issue_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset (resetn=0, asynchronous): every output is 0, ern included, and all counters are 0. Reset takes effect mid-cycle regardless of clock.
- After resetn deasserts, the first rising edge loads normally.
- The register loads every rising edge; there is no hold or enable. Latency is 1 cycle from d* to e*.
- Data fields (ea, eb, eimm, epc4, drn) load unconditionally, including during stalls and bubbles.
- Stall (wpcir=0): ewreg, em2reg, ewmem, ejal, ealuimm, eshift and ealuc load 0 regardless of their inputs. This is a defensive bubble; the control unit also zeroes them. evalid loads 0.
- Branch cancel: ebubble loads (dpcsource != 2'b00) & wpcir.
  - ebubble is therefore high for exactly the one cycle in which the instruction fetched after a taken branch or jump sits in ID.
  - The control unit zeroes that instruction's controls, so its dpcsource is 0 and ebubble cannot chain to consecutive cycles.
- evalid loads wpcir & ~ebubble, where ebubble is its current value.
  - In the cycle after a cancelled slot instruction, evalid is therefore 0.
  - wpcir=0 and ebubble=1 together: evalid loads 0 and ebubble loads 0.
- ern is combinational from registered state: ejal ? 5'd31 : rn_q.
- Counters update on the rising edge:
  - stall_cnt increments when wpcir=0.
  - bubble_cnt increments when ebubble=1 (current value).
  - issue_cnt increments when wpcir=1 and ebubble=0.
  - Each counter saturates at all-ones and does not wrap.
  - cnt_clr=1 forces all three counters to 0 on that edge; clear has priority over increment.
- Only the counters carry memory beyond one cycle. There is no other state.

Test Plan:
- Reset: drive nonzero inputs and assert resetn=0 between clock edges. All outputs go to 0 immediately, ern=0. On the first edge after release, ewreg/ealuc/ea follow the inputs (e.g. daluc=4'b0100, da=32'h1234 gives ealuc=4'b0100, ea=32'h1234 one cycle later).
- jal path: djal=1, drn=5'd0, dwreg=1, dpcsource=2'b11, wpcir=1.
  - Next cycle: ern=31, ejal=1, ebubble=1.
  - With zeroed controls in the following cycle: ebubble=0, evalid=0, bubble_cnt=1.
- Load-use stall: wpcir=0 with dwreg=1, dwmem=1, daluc=4'b1111.
  - Next cycle: ewreg=0, ewmem=0, ealuc=0, evalid=0, stall_cnt increments by 1, and eb still equals db.
- Simultaneous events: ebubble=1 in the same cycle as wpcir=0 and dpcsource=2'b01.
  - Next cycle: ebubble=0, evalid=0.
  - Both stall_cnt and bubble_cnt increment; issue_cnt is unchanged.
- Saturation and clear: with CNT_W=4, hold wpcir=1 and ebubble=0 for 20 cycles.
  - issue_cnt stops at 4'hF.
  - Asserting cnt_clr=1 together with an increment condition gives 0 on the next edge.
